// File: rtl/sbox_inv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sbox_inv_arbiter
// Purpose  : Shares one combinational GF(2^8) inverse unit between the AES
//            state path (requester 0, N0_BYTES-byte SubBytes jobs) and the
//            key-schedule path (requester 1, N1_BYTES-byte SubWord jobs).
//            Jobs are granted round-robin, fed one byte per cycle, and the
//            RES_W-bit redundant-basis results are collected per requester.
// Ports    : clk, reset                  clock, async active-high reset
//            reqK_valid/reqK_data/reqK_ack  job request, data, accept pulse
//            resK_valid/resK_data/resK_ready result handshake (held to ready)
//            inv_data/inv_result/inv_active external inverse unit interface
// Revision : 1.0  initial release
// ============================================================================
module sbox_inv_arbiter #(
   parameter int N0_BYTES = 16,
   parameter int N1_BYTES = 4,
   parameter int RES_W    = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req0_valid,
   input  logic [8*N0_BYTES-1:0]     req0_data,
   output logic                      req0_ack,
   output logic                      res0_valid,
   output logic [RES_W*N0_BYTES-1:0] res0_data,
   input  logic                      res0_ready,
   input  logic                      req1_valid,
   input  logic [8*N1_BYTES-1:0]     req1_data,
   output logic                      req1_ack,
   output logic                      res1_valid,
   output logic [RES_W*N1_BYTES-1:0] res1_data,
   input  logic                      res1_ready,
   output logic [7:0]                inv_data,
   input  logic [RES_W-1:0]          inv_result,
   output logic                      inv_active
);

   localparam int MAX_BYTES = (N0_BYTES > N1_BYTES) ? N0_BYTES : N1_BYTES;
   localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

   localparam logic [IDX_W-1:0] c_idx_zero = '0;
   localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
   localparam logic [IDX_W-1:0] c_last0    = IDX_W'(N0_BYTES - 1);
   localparam logic [IDX_W-1:0] c_last1    = IDX_W'(N1_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN0  = 3'd1,
      ST_RUN1  = 3'd2,
      ST_DONE0 = 3'd3,
      ST_DONE1 = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [IDX_W-1:0]          r_idx;
   logic [IDX_W-1:0]          w_idx_next;
   logic                      r_last_grant;
   logic                      w_last_grant_next;
   logic                      w_grant0;
   logic                      w_grant1;
   logic                      w_cap0;
   logic                      w_cap1;
   logic [8*MAX_BYTES-1:0]    r_job;
   logic [7:0]                w_cur_byte;
   logic [RES_W*N0_BYTES-1:0] r_res0;
   logic [RES_W*N1_BYTES-1:0] r_res1;

   // A single job register serves both requesters; a requester-1 job only
   // occupies the low N1_BYTES bytes.
   assign w_cur_byte = r_job[{r_idx, 3'b000} +: 8];

   assign res0_data = r_res0;
   assign res1_data = r_res1;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_idx        <= c_idx_zero;
         r_last_grant <= 1'b1;   // requester 0 wins the first tie
      end else begin
         r_state      <= w_state_next;
         r_idx        <= w_idx_next;
         r_last_grant <= w_last_grant_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next      = r_state;
      w_idx_next        = r_idx;
      w_last_grant_next = r_last_grant;
      w_grant0          = 1'b0;
      w_grant1          = 1'b0;
      w_cap0            = 1'b0;
      w_cap1            = 1'b0;
      req0_ack          = 1'b0;
      req1_ack          = 1'b0;
      res0_valid        = 1'b0;
      res1_valid        = 1'b0;
      inv_active        = 1'b0;
      inv_data          = 8'h00;

      case (r_state)
         ST_IDLE: begin
            w_idx_next = c_idx_zero;
            // On a tie the requester that was not served last wins.
            if (req0_valid && (!req1_valid || r_last_grant)) begin
               w_grant0     = 1'b1;
               w_state_next = ST_RUN0;
            end else if (req1_valid) begin
               w_grant1     = 1'b1;
               w_state_next = ST_RUN1;
            end
         end

         ST_RUN0: begin
            inv_active = 1'b1;
            inv_data   = w_cur_byte;
            req0_ack   = (r_idx == c_idx_zero);
            w_cap0     = 1'b1;
            if (r_idx == c_last0) begin
               w_state_next = ST_DONE0;
               w_idx_next   = c_idx_zero;
            end else begin
               w_idx_next = r_idx + c_idx_one;
            end
         end

         ST_RUN1: begin
            inv_active = 1'b1;
            inv_data   = w_cur_byte;
            req1_ack   = (r_idx == c_idx_zero);
            w_cap1     = 1'b1;
            if (r_idx == c_last1) begin
               w_state_next = ST_DONE1;
               w_idx_next   = c_idx_zero;
            end else begin
               w_idx_next = r_idx + c_idx_one;
            end
         end

         ST_DONE0: begin
            res0_valid = 1'b1;
            if (res0_ready) begin
               w_state_next      = ST_IDLE;
               w_last_grant_next = 1'b0;
            end
         end

         ST_DONE1: begin
            res1_valid = 1'b1;
            if (res1_ready) begin
               w_state_next      = ST_IDLE;
               w_last_grant_next = 1'b1;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
            w_idx_next   = c_idx_zero;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Job capture and result collection
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_job  <= '0;
         r_res0 <= '0;
         r_res1 <= '0;
      end else begin
         if (w_grant0) begin
            r_job                   <= '0;
            r_job[8*N0_BYTES-1:0]   <= req0_data;
         end else if (w_grant1) begin
            r_job                   <= '0;
            r_job[8*N1_BYTES-1:0]   <= req1_data;
         end
         // Results stay put until the same requester's next job overwrites
         // them slot by slot.
         if (w_cap0) begin
            r_res0[RES_W*r_idx +: RES_W] <= inv_result;
         end
         if (w_cap1) begin
            r_res1[RES_W*r_idx +: RES_W] <= inv_result;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sbox_inv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_inv_arbiter
// Purpose  : Directed self-checking bench for sbox_inv_arbiter. Models the
//            external inverse unit (AES-field inverse plus two nibble-parity
//            bits as the redundant basis) and walks through single jobs,
//            arbitration ties, result back-pressure, mid-job reset and
//            stray ready pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_sbox_inv_arbiter;

   localparam int N0_BYTES = 16;
   localparam int N1_BYTES = 4;
   localparam int RES_W    = 10;

   logic                      clk;
   logic                      reset;
   logic                      req0_valid;
   logic [8*N0_BYTES-1:0]     req0_data;
   logic                      req0_ack;
   logic                      res0_valid;
   logic [RES_W*N0_BYTES-1:0] res0_data;
   logic                      res0_ready;
   logic                      req1_valid;
   logic [8*N1_BYTES-1:0]     req1_data;
   logic                      req1_ack;
   logic                      res1_valid;
   logic [RES_W*N1_BYTES-1:0] res1_data;
   logic                      res1_ready;
   logic [7:0]                inv_data;
   logic [RES_W-1:0]          inv_result;
   logic                      inv_active;

   int n_vec = 0;
   int n_err = 0;

   sbox_inv_arbiter #(
      .N0_BYTES (N0_BYTES),
      .N1_BYTES (N1_BYTES),
      .RES_W    (RES_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ack   (req0_ack),
      .res0_valid (res0_valid),
      .res0_data  (res0_data),
      .res0_ready (res0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ack   (req1_ack),
      .res1_valid (res1_valid),
      .res1_data  (res1_data),
      .res1_ready (res1_ready),
      .inv_data   (inv_data),
      .inv_result (inv_result),
      .inv_active (inv_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- inverse-unit model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b);
      logic [7:0] a;
      logic [7:0] p;
      a = a_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      if (x == 8'h00) return 8'h00;
      for (int k = 1; k < 256; k++) begin
         if (gf_mul(x, 8'(k)) == 8'h01) return 8'(k);
      end
      return 8'h00;
   endfunction

   function automatic logic [9:0] red(input logic [7:0] x);
      logic [7:0] y;
      y = gf_inv(x);
      return {^y[7:4], ^y[3:0], y};
   endfunction

   always_comb inv_result = red(inv_data);

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [159:0] exp0;
      logic [39:0]  exp1;
      logic [159:0] held0;

      reset      = 1'b1;
      req0_valid = 1'b0;
      req0_data  = '0;
      res0_ready = 1'b0;
      req1_valid = 1'b0;
      req1_data  = '0;
      res1_ready = 1'b0;
      step();
      step();

      // Reset state
      check("rst_req0_ack",   160'(req0_ack),   160'(0));
      check("rst_req1_ack",   160'(req1_ack),   160'(0));
      check("rst_res0_valid", 160'(res0_valid), 160'(0));
      check("rst_res1_valid", 160'(res1_valid), 160'(0));
      check("rst_res0_data",  160'(res0_data),  160'(0));
      check("rst_res1_data",  160'(res1_data),  160'(0));
      check("rst_inv",        160'({inv_active, inv_data}), 160'(0));
      reset = 1'b0;
      step();

      // ---- Single requester-1 job ----
      req1_valid = 1'b1;
      req1_data  = 32'h03020100;
      step();                                   // accept edge E0
      check("t1_ack1", 160'(req1_ack), 160'(1));
      check("t1_ack0", 160'(req0_ack), 160'(0));
      check("t1_byte0", 160'({inv_active, inv_data}), 160'({1'b1, 8'h00}));
      req1_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         step();
         check("t1_byte", 160'({inv_active, inv_data}), 160'({1'b1, 8'(k)}));
         if (k == 1) check("t1_ack1_once", 160'(req1_ack), 160'(0));
         if (k == 3) check("t1_res1_early", 160'(res1_valid), 160'(0));
      end
      step();                                   // E4
      check("t1_res1_valid", 160'(res1_valid), 160'(1));
      check("t1_inv_idle",   160'({inv_active, inv_data}), 160'(0));
      check("t1_res1_data",  160'(res1_data),
            160'({10'h0F6, 10'h38D, 10'h101, 10'h000}));
      step();
      check("t1_res1_hold", 160'(res1_valid), 160'(1));
      res1_ready = 1'b1;
      step();
      res1_ready = 1'b0;
      check("t1_res1_consumed", 160'(res1_valid), 160'(0));
      check("t1_res1_data_kept", 160'(res1_data),
            160'({10'h0F6, 10'h38D, 10'h101, 10'h000}));

      // ---- Single requester-0 job, bytes 0x00..0x0F ----
      for (int i = 0; i < 16; i++) begin
         req0_data[8*i +: 8] = 8'(i);
         exp0[10*i +: 10]    = red(8'(i));
      end
      req0_valid = 1'b1;
      step();                                   // E0
      check("t2_ack0", 160'(req0_ack), 160'(1));
      req0_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("t2_byte", 160'({inv_active, inv_data}), 160'({1'b1, 8'(i)}));
         if (i == 15) check("t2_res0_early", 160'(res0_valid), 160'(0));
         step();
      end
      check("t2_res0_valid", 160'(res0_valid), 160'(1));
      check("t2_res0_data",  res0_data, exp0);
      check("t2_inv_idle",   160'(inv_active), 160'(0));
      res0_ready = 1'b1;
      step();
      res0_ready = 1'b0;
      check("t2_consumed", 160'(res0_valid), 160'(0));

      // ---- Ties from reset, back-pressure, stray res1_ready ----
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         req0_data[8*i +: 8] = 8'(8'h10 + i);
         exp0[10*i +: 10]    = red(8'(8'h10 + i));
      end
      req1_data  = 32'hDDCCBBAA;
      exp1       = {red(8'hDD), red(8'hCC), red(8'hBB), red(8'hAA)};
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      check("t3_tie_ack0", 160'(req0_ack), 160'(1));
      check("t3_tie_ack1", 160'(req1_ack), 160'(0));
      for (int i = 1; i < 16; i++) begin
         if (i == 5) res1_ready = 1'b1;
         step();
         res1_ready = 1'b0;
         check("t3_run0_byte", 160'({inv_active, inv_data}), 160'({1'b1, 8'(8'h10 + i)}));
         if (i == 5) check("t6_res1_stray", 160'(res1_valid), 160'(0));
      end
      step();
      check("t3_res0_valid", 160'(res0_valid), 160'(1));
      check("t3_res0_data",  res0_data, exp0);
      held0 = res0_data;
      for (int c = 0; c < 10; c++) begin
         step();
         check("t4_hold_valid", 160'(res0_valid), 160'(1));
         check("t4_hold_data",  res0_data, held0);
         check("t4_no_ack1",    160'(req1_ack), 160'(0));
      end
      res0_ready = 1'b1;
      step();
      res0_ready = 1'b0;
      check("t4_idle_ack1", 160'(req1_ack), 160'(0));
      check("t4_idle_res0", 160'(res0_valid), 160'(0));
      step();
      check("t3_alt_ack1", 160'(req1_ack), 160'(1));
      check("t3_alt_ack0", 160'(req0_ack), 160'(0));
      check("t3_alt_byte", 160'(inv_data), 160'(8'hAA));
      for (int k = 0; k < 4; k++) step();
      check("t3_res1_valid", 160'(res1_valid), 160'(1));
      check("t3_res1_data",  160'(res1_data), 160'(exp1));
      res1_ready = 1'b1;
      step();
      res1_ready = 1'b0;
      req1_valid = 1'b0;
      step();
      check("t3_alt_back_ack0", 160'(req0_ack), 160'(1));
      req0_valid = 1'b0;
      for (int k = 0; k < 16; k++) step();
      check("t3_second_res0", 160'(res0_valid), 160'(1));
      res0_ready = 1'b1;
      step();
      res0_ready = 1'b0;

      // ---- Reset in the middle of a requester-0 job ----
      for (int i = 0; i < 16; i++) begin
         req0_data[8*i +: 8] = 8'(8'hA0 + i);
         exp0[10*i +: 10]    = red(8'(8'hA0 + i));
      end
      req0_valid = 1'b1;
      step();
      check("t5_ack0", 160'(req0_ack), 160'(1));
      for (int k = 0; k < 7; k++) step();
      check("t5_idx7", 160'({inv_active, inv_data}), 160'({1'b1, 8'hA7}));
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_inv",    160'({inv_active, inv_data}), 160'(0));
      check("t5_rst_ack0",   160'(req0_ack), 160'(0));
      check("t5_rst_valid0", 160'(res0_valid), 160'(0));
      check("t5_rst_data0",  160'(res0_data), 160'(0));
      #3;
      reset = 1'b0;
      step();
      check("t5_restart_ack0", 160'(req0_ack), 160'(1));
      check("t5_restart_byte", 160'({inv_active, inv_data}), 160'({1'b1, 8'hA0}));
      req0_valid = 1'b0;
      for (int k = 1; k < 16; k++) step();
      check("t5_no_early_res0", 160'(res0_valid), 160'(0));
      step();
      check("t5_res0_valid", 160'(res0_valid), 160'(1));
      check("t5_res0_data",  res0_data, exp0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sbox_inv_arbiter.md
Name: sbox_inv_arbiter

Overview:
- Shares one combinational GF(2^8) inverse datapath between two requesters:
  - requester 0 is the AES state path, with 16-byte jobs (SubBytes).
  - requester 1 is the key-schedule path, with 4-byte jobs (SubWord).
- Arbitration is round-robin at job granularity. The granted job is fed to the inverse unit one byte per cycle, and the 10-bit redundant-basis results are collected into a result vector.
- Basis conversion and the affine transform stay in the requesters.

Parameters:
- N0_BYTES, 16: byte count of a requester-0 job.
- N1_BYTES, 4: byte count of a requester-1 job.
- RES_W, 10: width of one inverse result (redundant basis).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a job pending.
- req0_data  input  8*N0_BYTES  job bytes; byte i = bits [8i+7:8i].
- req0_ack  output  1  one-cycle pulse: job 0 accepted.
- res0_valid  output  1  requester-0 results available, held until consumed.
- res0_data  output  RES_W*N0_BYTES  result i = bits [RES_W*i+RES_W-1:RES_W*i].
- res0_ready  input  1  requester 0 consumes its result.
- req1_valid, req1_data (8*N1_BYTES), req1_ack, res1_valid, res1_data (RES_W*N1_BYTES), res1_ready: same as requester 0, for requester 1.
- inv_data  output  8  byte driven to the inverse unit.
- inv_result  input  RES_W  combinational inverse of inv_data.
- inv_active  output  1  inv_data carries a live byte this cycle.

Behaviour:
- Reset (asynchronous, any state) forces:
  - state to IDLE, byte index 0, last_grant=1 (so requester 0 wins the first tie).
  - all outputs to 0, including res*_data.
  - An in-flight job is aborted: no ack repeat, no res_valid.
- States: IDLE, RUN0, RUN1, DONE0, DONE1.
- IDLE:
  - Only one valid: grant that requester.
  - Both valid: grant the requester not equal to last_grant.
  - On the grant edge: capture req*_data into an internal job register; clear the index to 0; enter RUNk.
  - req*_valid is sampled only in IDLE. A valid held high during RUN/DONE is not a new request.
- RUNk:
  - Combinational outputs: inv_data = job byte[index]; inv_active = 1.
  - req k_ack = 1 only in the first RUN cycle (index 0).
  - Each edge: result[index] <= inv_result, then index++.
  - At index = Nk-1: capture the last byte, go to DONEk, index <= 0.
- Timing:
  - If the accept edge is E0, res k_valid rises at edge E_Nk: 16 edges for requester 0, 4 for requester 1.
  - Throughput: 1 byte per cycle.
- DONEk:
  - res k_valid = 1; res k_data stable.
  - inv_active = 0; inv_data = 0.
  - On an edge with res k_ready = 1: go to IDLE, set last_grant = k.
  - res k_data holds its value until the next job of the same requester overwrites it.
  - res k_ready is ignored outside DONEk.
- Because the grant happens in IDLE only, a DONE→IDLE→RUN turnaround costs 1 idle cycle.
- Starvation bound: a waiting requester is granted no later than the next IDLE after the current job.
- Result index wraps are not possible: the index is bounded by Nk-1 and cleared on every state entry.

Test Plan:
- Single req1 job with data 32'h03020100 → req1_ack pulses the cycle after the accept edge; inv_data sequence is 00,01,02,03; res1_valid rises 4 edges after accept; res1_data[9:0]=10'h000 and the other slots match an inverse-unit model.
- Single req0 job of 16 bytes 0x00..0x0F → 16 consecutive inv_active cycles; res0_valid rises at edge 16; all 16 results match the model; res0_ready pulse returns the block to IDLE.
- Both valid from reset → requester 0 granted first. With both valid again after res0 is consumed, requester 1 is granted. The next tie goes to requester 0 (alternation).
- res0_ready held low for 10 cycles in DONE0 → res0_valid and res0_data are stable throughout; req1_valid is high but not acked until the edge after res0_ready.
- Reset asserted at index 7 of a req0 job → all outputs go to 0 immediately; no res0_valid appears. After release with req0_valid high, the job restarts from byte 0 with a fresh req0_ack.
- res1_ready pulsed while in RUN0 → no effect: RUN0 proceeds and res1_valid stays 0.
